// File: rtl/vgaconsole_pkg.sv
// rtl/vgaconsole_pkg.sv - shared constants and types for the VGA console terminal controller
//
// Purpose: geometry of the text buffer, blank-fill attributes, control code
// values, the controller state enum and the cursor command enum.
package vgaconsole_pkg;

  localparam int NUM_ROWS         = 3;
  localparam int NUM_COLS         = 10;
  localparam int NUM_CHARS        = NUM_ROWS * NUM_COLS;
  localparam int ROWS_ADDR_WIDTH  = (NUM_ROWS  > 1) ? $clog2(NUM_ROWS)  : 1;
  localparam int COLS_ADDR_WIDTH  = (NUM_COLS  > 1) ? $clog2(NUM_COLS)  : 1;
  localparam int CHARS_ADDR_WIDTH = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  localparam logic [2:0] DEFAULT_TEXT_COLOR = 3'b010;
  localparam logic [6:0] BLANK_CHAR         = 7'h20;
  localparam logic [9:0] BLANK_CELL         = {DEFAULT_TEXT_COLOR, BLANK_CHAR};

  localparam logic [7:0] CHAR_BS     = 8'h08;
  localparam logic [7:0] CHAR_LF     = 8'h0A;
  localparam logic [7:0] CHAR_FF     = 8'h0C;
  localparam logic [7:0] CHAR_CR     = 8'h0D;
  localparam logic [7:0] PRINT_FIRST = 8'h20;
  localparam logic [7:0] PRINT_LAST  = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCROLL_COPY,
    ST_SCROLL_CLEAR,
    ST_CLEAR
  } state_e;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADVANCE,  // col+1, wrapping to col 0 with a newline
    CUR_LF,       // col 0 and newline
    CUR_CR,       // col 0
    CUR_BACK,     // col-1 unless already at col 0
    CUR_HOME      // (0,0)
  } cur_cmd_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_FIRST) && (c <= PRINT_LAST);
  endfunction

endpackage

// File: rtl/vgaconsole_cursor.sv
// rtl/vgaconsole_cursor.sv - text cursor row/column registers
//
// Purpose: holds the cursor position and applies one command per cycle.
// A newline on the last row leaves the row unchanged; the controller is
// responsible for scrolling the buffer in that case.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (cursor -> (0,0))
//   cmd           cursor command for this cycle
//   row, col      current cursor position
//   at_last_col   col == NUM_COLS-1
//   at_last_row   row == NUM_ROWS-1
//   addr          linear buffer address row*NUM_COLS+col
module vgaconsole_cursor
  import vgaconsole_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  cur_cmd_e                    cmd,
  output logic [ROWS_ADDR_WIDTH-1:0]  row,
  output logic [COLS_ADDR_WIDTH-1:0]  col,
  output logic                        at_last_col,
  output logic                        at_last_row,
  output logic [CHARS_ADDR_WIDTH-1:0] addr
);

  localparam logic [ROWS_ADDR_WIDTH-1:0]  LAST_ROW   = ROWS_ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [COLS_ADDR_WIDTH-1:0]  LAST_COL   = COLS_ADDR_WIDTH'(NUM_COLS - 1);
  localparam logic [ROWS_ADDR_WIDTH-1:0]  ROW_ONE    = ROWS_ADDR_WIDTH'(1);
  localparam logic [COLS_ADDR_WIDTH-1:0]  COL_ONE    = COLS_ADDR_WIDTH'(1);
  localparam logic [CHARS_ADDR_WIDTH-1:0] ROW_STRIDE = CHARS_ADDR_WIDTH'(NUM_COLS);

  logic [ROWS_ADDR_WIDTH-1:0] row_q, row_d;
  logic [COLS_ADDR_WIDTH-1:0] col_q, col_d;

  assign row         = row_q;
  assign col         = col_q;
  assign at_last_col = (col_q == LAST_COL);
  assign at_last_row = (row_q == LAST_ROW);
  assign addr        = CHARS_ADDR_WIDTH'(row_q) * ROW_STRIDE + CHARS_ADDR_WIDTH'(col_q);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    case (cmd)
      CUR_ADVANCE: begin
        if (at_last_col) begin
          col_d = '0;
          if (!at_last_row) row_d = row_q + ROW_ONE;
        end else begin
          col_d = col_q + COL_ONE;
        end
      end
      CUR_LF: begin
        col_d = '0;
        if (!at_last_row) row_d = row_q + ROW_ONE;
      end
      CUR_CR:   col_d = '0;
      CUR_BACK: if (col_q != '0) col_d = col_q - COL_ONE;
      CUR_HOME: begin
        row_d = '0;
        col_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/vgaconsole_term_ctrl.sv
// rtl/vgaconsole_term_ctrl.sv - terminal write controller for the VGA text buffer
//
// Purpose: accepts a byte stream, places printables at the cursor, handles
// LF/CR/BS/FF, and sequences scroll (row copy + last-row blank) and full
// screen clears into the text buffer. A clear runs automatically after reset.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      byte handshake; bytes accepted only in IDLE
//   in_char, in_color      byte and colour for printables
//   buf_we/addr/wdata      registered buffer write port
//   buf_raddr/buf_rdata    combinational buffer read port (scroll copy)
//   cursor_row/cursor_col  cursor position
//   busy                   controller is sequencing a scroll or clear
module vgaconsole_term_ctrl
  import vgaconsole_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  in_char,
  input  logic [2:0]                  in_color,
  output logic                        buf_we,
  output logic [CHARS_ADDR_WIDTH-1:0] buf_addr,
  output logic [9:0]                  buf_wdata,
  output logic [CHARS_ADDR_WIDTH-1:0] buf_raddr,
  input  logic [9:0]                  buf_rdata,
  output logic [ROWS_ADDR_WIDTH-1:0]  cursor_row,
  output logic [COLS_ADDR_WIDTH-1:0]  cursor_col,
  output logic                        busy
);

  localparam logic [CHARS_ADDR_WIDTH-1:0] IDX_ONE    = CHARS_ADDR_WIDTH'(1);
  localparam logic [CHARS_ADDR_WIDTH-1:0] COLS_OFF   = CHARS_ADDR_WIDTH'(NUM_COLS);
  localparam logic [CHARS_ADDR_WIDTH-1:0] COPY_LAST  = CHARS_ADDR_WIDTH'((NUM_ROWS - 1) * NUM_COLS - 1);
  localparam logic [CHARS_ADDR_WIDTH-1:0] CHARS_LAST = CHARS_ADDR_WIDTH'(NUM_CHARS - 1);

  state_e                        state_q, state_d;
  logic [CHARS_ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                          buf_we_q, buf_we_d;
  logic [CHARS_ADDR_WIDTH-1:0]   buf_addr_q, buf_addr_d;
  logic [9:0]                    buf_wdata_q, buf_wdata_d;
  logic [CHARS_ADDR_WIDTH-1:0]   raddr_c;

  cur_cmd_e                      cur_cmd;
  logic                          cur_at_last_col;
  logic                          cur_at_last_row;
  logic [CHARS_ADDR_WIDTH-1:0]   cur_addr;

  vgaconsole_cursor u_cursor (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cur_cmd),
    .row         (cursor_row),
    .col         (cursor_col),
    .at_last_col (cur_at_last_col),
    .at_last_row (cur_at_last_row),
    .addr        (cur_addr)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign buf_we    = buf_we_q;
  assign buf_addr  = buf_addr_q;
  assign buf_wdata = buf_wdata_q;
  assign buf_raddr = raddr_c;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_we_d    = 1'b0;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    raddr_c     = '0;
    cur_cmd     = CUR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_printable(in_char)) begin
            buf_we_d    = 1'b1;
            buf_addr_d  = cur_addr;
            buf_wdata_d = {in_color, in_char[6:0]};
            cur_cmd     = CUR_ADVANCE;
            // Wrapping off the bottom-right cell scrolls the screen.
            if (cur_at_last_col && cur_at_last_row) begin
              state_d = ST_SCROLL_COPY;
              idx_d   = '0;
            end
          end else begin
            case (in_char)
              CHAR_LF: begin
                cur_cmd = CUR_LF;
                if (cur_at_last_row) begin
                  state_d = ST_SCROLL_COPY;
                  idx_d   = '0;
                end
              end
              CHAR_CR: cur_cmd = CUR_CR;
              CHAR_BS: begin
                if (cursor_col != '0) begin
                  cur_cmd     = CUR_BACK;
                  buf_we_d    = 1'b1;
                  buf_addr_d  = cur_addr - IDX_ONE;
                  buf_wdata_d = BLANK_CELL;
                end
              end
              CHAR_FF: begin
                cur_cmd = CUR_HOME;
                state_d = ST_CLEAR;
                idx_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end

      // Read cell idx+NUM_COLS now; the registered write lands it at idx
      // next cycle, always behind the read pointer so no hazard exists.
      ST_SCROLL_COPY: begin
        raddr_c     = idx_q + COLS_OFF;
        buf_we_d    = 1'b1;
        buf_addr_d  = idx_q;
        buf_wdata_d = buf_rdata;
        idx_d       = idx_q + IDX_ONE;
        if (idx_q == COPY_LAST) state_d = ST_SCROLL_CLEAR;
      end

      // Scroll-clear continues from the first cell of the last row; a full
      // clear starts from 0. Both end on the last cell.
      ST_SCROLL_CLEAR, ST_CLEAR: begin
        buf_we_d    = 1'b1;
        buf_addr_d  = idx_q;
        buf_wdata_d = BLANK_CELL;
        if (idx_q == CHARS_LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      idx_q       <= '0;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_we_q    <= buf_we_d;
      buf_addr_q  <= buf_addr_d;
      buf_wdata_q <= buf_wdata_d;
    end
  end

endmodule
